// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and LeNet map dimensions.
package cnn_pkg;
  localparam int CNN_DATA_W = 32;
  localparam int C1_OUT_W   = 24;
  localparam int S2_OUT_W   = 12;

  typedef logic signed [CNN_DATA_W-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for the 2x2 pooling stage: combinational read, synchronous write.
module pool_line_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 12,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/maxpool2x2_stage.sv
// 2x2 stride-2 signed max-pooling over a raster-order IN_W x IN_H map.
// Optional fused ReLU on the pooled output when POOL_RELU_EN is defined.
module maxpool2x2_stage
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int IN_W   = C1_OUT_W,
  parameter int IN_H   = C1_OUT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     frame_done
);
  localparam int DEPTH = IN_W / 2;
  localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW    = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [DATA_W-1:0] pair_q, pair_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     frame_done_q, frame_done_d;

  logic                     lb_we;
  logic [AW-1:0]            lb_addr;
  logic signed [DATA_W-1:0] lb_rdata;
  logic signed [DATA_W-1:0] pmax, wmax, win_res;

  // Both read and write use the half-column index of the current beat.
  assign lb_addr = AW'(col_q >> 1);

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we & ~reset),
    .waddr (lb_addr),
    .wdata (pmax),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  assign pmax = (pair_q > in_data) ? pair_q : in_data;
  assign wmax = (lb_rdata > pmax) ? lb_rdata : pmax;

`ifdef POOL_RELU_EN
  assign win_res = wmax[DATA_W-1] ? '0 : wmax;
`else
  assign win_res = wmax;
`endif

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    lb_we        = 1'b0;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_q[0]) begin
        pair_d = in_data;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        out_data_d   = win_res;
        frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_maxpool2x2_stage.sv
// Scoreboard bench for maxpool2x2_stage at the default 24x24 geometry.
module tb_maxpool2x2_stage;
  localparam int DW = 32;
  localparam int W  = 24;
  localparam int H  = 24;
  localparam int NPIX = W * H;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 frame_done;

  typedef struct {
    logic signed [DW-1:0] d;
    logic                 fd;
  } exp_t;

  exp_t                 sb[$];
  exp_t                 mx;
  int                   n_chk = 0, n_fail = 0, n_ov = 0, n_fd = 0;
  logic signed [DW-1:0] fm [NPIX];

  always #5 clk = ~clk;

  maxpool2x2_stage #(.DATA_W(DW), .IN_W(W), .IN_H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] model(input int r, input int c);
    logic signed [DW-1:0] v [4];
    logic signed [DW-1:0] m;
    v[0] = fm[(2*r)*W + 2*c];
    v[1] = fm[(2*r)*W + 2*c + 1];
    v[2] = fm[(2*r+1)*W + 2*c];
    v[3] = fm[(2*r+1)*W + 2*c + 1];
    m = v[0];
    for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
`ifdef POOL_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      n_ov++;
      if (frame_done) n_fd++;
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(1), 64'(0));
      end else begin
        mx = sb.pop_front();
        check("out_data", 64'(out_data), 64'(mx.d));
        check("frame_done", 64'(frame_done), 64'(mx.fd));
      end
    end else if (frame_done) begin
      check("stray_frame_done", 64'(frame_done), 64'(0));
    end
  end

  task automatic beat(input logic signed [DW-1:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Drives pixels first..last; stall_at inserts a 50-cycle in_valid=0 gap before that pixel.
  task automatic send(input int first, input int last, input bit toggle, input int stall_at);
    int r, c, ov0;
    logic signed [DW-1:0] hold;
    for (int i = first; i <= last; i++) begin
      if (i == stall_at) begin
        idle(2);
        ov0  = n_ov;
        hold = out_data;
        idle(48);
        check("stall_no_valid", 64'(n_ov - ov0), 64'(0));
        check("stall_out_hold", 64'(out_data), 64'(hold));
      end
      r = i / W;
      c = i % W;
      if ((r % 2 == 1) && (c % 2 == 1))
        sb.push_back('{model(r/2, c/2), (r == H-1) && (c == W-1)});
      beat(fm[i]);
      if (toggle) idle(1);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) fm[i] = $signed($urandom);
  endtask

  initial begin
    int ov0, fd0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    reset = 1'b0;

    // Ramp frame immediately followed by an all-negative frame.
    for (int i = 0; i < NPIX; i++) fm[i] = i;
    ov0 = n_ov; fd0 = n_fd;
    send(0, NPIX-1, 1'b0, -1);
    for (int i = 0; i < NPIX; i++) fm[i] = -(i + 1);
    send(0, NPIX-1, 1'b0, -1);
    idle(3);
    check("b2b_ov_count", 64'(n_ov - ov0), 64'(288));
    check("b2b_fd_count", 64'(n_fd - fd0), 64'(2));

    // Mixed-sign corner window plus toggled in_valid, then second frame with a long stall.
    fill_random();
    fm[0] = -5; fm[1] = 3; fm[W] = 32'sh7FFF_FFFF; fm[W+1] = 32'sh8000_0000;
    ov0 = n_ov; fd0 = n_fd;
    send(0, NPIX-1, 1'b1, -1);
    idle(3);
    check("tog_ov_count", 64'(n_ov - ov0), 64'(144));
    check("tog_fd_count", 64'(n_fd - fd0), 64'(1));
    fill_random();
    send(0, NPIX-1, 1'b1, 13*W + 12);
    idle(3);
    check("tog2_ov_count", 64'(n_ov - ov0), 64'(288));
    check("tog2_fd_count", 64'(n_fd - fd0), 64'(2));

    // Reset mid-frame with a window-completing beat presented in the reset cycle.
    fill_random();
    ov0 = n_ov; fd0 = n_fd;
    send(0, 5*W + 10, 1'b0, -1);
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'sh7FFF_FFFF;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    idle(5);
    check("rst_mid_ov_count", 64'(n_ov - ov0), 64'(29));
    check("rst_mid_fd_count", 64'(n_fd - fd0), 64'(0));
    check("rst_mid_out_data", 64'(out_data), 64'(0));
    check("rst_mid_sb_empty", 64'(sb.size()), 64'(0));
    sb.delete();

    fill_random();
    ov0 = n_ov; fd0 = n_fd;
    send(0, NPIX-1, 1'b0, -1);
    idle(3);
    check("post_rst_ov_count", 64'(n_ov - ov0), 64'(144));
    check("post_rst_fd_count", 64'(n_fd - fd0), 64'(1));
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
